vq_lbg_16x13_sdpram: RTL and testbench
======================================

Name: vq_lbg_16x13_sdpram

Overview:
- Simple dual-port RAM, 256 words x 14 bits: one write port, one read port, one shared clock.
- Stores the vector-quantisation (LBG) codebook for the audio-processing path.
  - The codebook writer fills entries through the write port.
  - The distance/search logic fetches entries by address through the read port.
- Contents are not initialised (no init file); power-up contents are undefined until written.

Parameters:
- ADDR_WIDTH, 8, width of wr_addr and rd_addr; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 14, width of wr_data and rd_data.

Ports:
- clk  input  1  single clock for both write and read ports; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset; affects the read output register(s) only.
- wr_data  input  DATA_WIDTH  write data.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_en  input  1  write strobe, active high.
- rd_addr  input  ADDR_WIDTH  read address; the port is always reading (no read enable).
- rd_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Write:
  - On a rising clk edge with wr_en=1, mem[wr_addr] <= wr_data.
  - With wr_en=0, memory is unchanged.
  - No byte enables; no address strobe.
- Read:
  - On every rising clk edge (rst_n high), rd_data <= mem[rd_addr].
  - Latency is 1 cycle: address presented before edge N gives data valid after edge N.
- Reset:
  - rst_n low forces rd_data to 0 immediately (asynchronous).
  - rd_data is held at 0 while rst_n is low.
  - Release is synchronous to the next rising edge: the first read occurs at the first edge with rst_n high.
  - Memory array contents are NOT cleared by reset; data written before reset is readable after it.
  - Writes are ignored while rst_n is low.
- Read-during-write to the same address on the same edge: read-first. rd_data returns the old contents; the new data is visible one cycle later.
- Read and write to different addresses on the same edge are fully independent.
- Addresses cover the full 0..2**ADDR_WIDTH-1 range; there is no out-of-range case.
- Unwritten locations read as X in simulation (undefined).
- Implementation: infer block RAM via a registered-read template. The reset applies only to the output register, so the array itself is not reset.

Optional Feature:
- Macro: VQ_LBG_OUTPUT_REG_EN.
- Defined:
  - An extra output pipeline register follows the RAM read register.
  - Read latency becomes 2 cycles.
  - Both registers reset asynchronously to 0 on rst_n low.
  - Read-first collision behaviour is unchanged, just delayed one cycle.
- Not defined: 1-cycle latency as described above.

Test Plan:
- Fill and readback:
  - Reset low 200 ns, release.
  - Write addr 0..255 with data 0x3FFF-addr (wr_en=1, one word per cycle).
  - Read addr 0..255 back to back.
  - Required: rd_data = 0x3FFF-addr one cycle after each address (two with VQ_LBG_OUTPUT_REG_EN); zero mismatches.
- Write-enable gating:
  - Write 0x1234 to addr 0x10.
  - Then drive addr 0x10, data 0x0000 with wr_en=0.
  - Read 0x10 -> 0x1234.
- Read-during-write:
  - addr 0x20 holds 0x0AAA.
  - Same edge: write 0x1555 to 0x20 and read 0x20.
  - rd_data = 0x0AAA; next cycle reading 0x20 -> 0x1555.
- Reset mid-operation:
  - While streaming reads, assert rst_n low between clock edges.
  - rd_data goes to 0 immediately and stays 0 while low.
  - After release, reading addr 0x05 returns the value written before reset (memory retained).
- Boundary addresses:
  - Write 0x3FFF to addr 0xFF and 0x0001 to addr 0x00.
  - Read 0xFF then 0x00 back to back -> 0x3FFF then 0x0001.
- Simultaneous independent access:
  - Write 0x0F0F to 0x40 while reading 0x41 (holding 0x00F0) on the same edge.
  - rd_data = 0x00F0; later read of 0x40 -> 0x0F0F.

Source files
------------

// File: rtl/vq_lbg_16x13_sdpram.sv
// Simple dual-port RAM holding the LBG vector-quantisation codebook: one write port, one read port, one clock.
// Latency: 1 cycle from rd_addr to rd_data, or 2 cycles when VQ_LBG_OUTPUT_REG_EN is defined.
// Backpressure: none. Writes are accepted on any edge with wr_en high, and the read port reads on every edge.
//
// Ports:
//   clk      - shared rising-edge clock for both ports
//   rst_n    - async active-low reset; clears only the read output register(s)
//   wr_data  - write data (DATA_WIDTH)
//   wr_addr  - write address (ADDR_WIDTH)
//   wr_en    - write strobe, active high; ignored while rst_n is low
//   rd_addr  - read address (ADDR_WIDTH); this port is always reading
//   rd_data  - registered read data (DATA_WIDTH)
//
// Optional build macro: VQ_LBG_OUTPUT_REG_EN adds a second output pipeline register.
module vq_lbg_16x13_sdpram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // The array has no reset, so it can map onto a block RAM. Its contents survive rst_n.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // RAM read register. It samples the array before this edge's write lands, so a
  // collision on the same address returns the old word (read-first).
  logic [DATA_WIDTH-1:0] rd_q;

  // rst_n gates the write so the codebook cannot be corrupted while the block is held in reset.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

`ifdef VQ_LBG_OUTPUT_REG_EN
  // Extra output stage for timing closure. It delays everything, including collision results, by one cycle.
  logic [DATA_WIDTH-1:0] rd_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q2 <= '0;
    end else begin
      rd_q2 <= rd_q;
    end
  end

  assign rd_data = rd_q2;
`else
  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_vq_lbg_16x13_sdpram.sv
module tb_vq_lbg_16x13_sdpram;

`ifdef VQ_LBG_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [13:0] wr_data;
  logic [7:0]  wr_addr;
  logic        wr_en;
  logic [7:0]  rd_addr;
  logic [13:0] rd_data;

  vq_lbg_16x13_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(14)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain array of words plus a queue of reads in flight.
  logic [13:0] model [256];
  logic [13:0] rq [$];
  int          passed = 0;
  int          total  = 0;
  string       tag    = "reset";

  task automatic chk(input string t, input logic [13:0] obs, input logic [13:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", t, obs, expv);
  endtask

  // Drive one cycle of inputs, then apply the read-first rule in the model.
  // Inputs change 1 time unit after the rising edge, and rd_data is sampled at the same point.
  task automatic step(input logic we, input logic [7:0] wa, input logic [13:0] wd,
                      input logic [7:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    @(posedge clk);
    rq.push_back(model[ra]);           // old contents are read
    if (we) model[wa] = wd;            // then the write lands
    if (rq.size() > LAT) void'(rq.pop_front());
    #1;
    if (rq.size() == LAT && !$isunknown(rq[0])) chk(tag, rd_data, rq[0]);
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++) step(1'b0, 8'h00, 14'h0000, 8'h00);
  endtask

  // Assert reset between edges, hold it across a few edges that attempt writes, then release between edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", rd_data, 14'h0000);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 8'h05; wr_data = 14'($urandom); rd_addr = 8'h05;
      @(posedge clk);
      #1;
      chk("rst_hold", rd_data, 14'h0000);
    end
    wr_en = 1'b0;
    #2;
    rst_n = 1'b1;
    rq.delete();
    // Any extra output stage re-emerges from reset holding zero.
    for (int i = 0; i < LAT - 1; i++) rq.push_back(14'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  a;
    logic [13:0] d;
    for (int i = 0; i < 256; i++) model[i] = 'x;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    #200;
    chk("reset_state", rd_data, 14'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < LAT - 1; i++) rq.push_back(14'h0000);

    // Fill every address with 0x3FFF-addr while reading random addresses.
    tag = "fill";
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 14'(14'h3FFF - i), 8'($urandom));
    tag = "readback";
    for (int i = 0; i < 256; i++) step(1'b0, 8'($urandom), 14'($urandom), 8'(i));
    flush();

    tag = "wr_en_gate";
    step(1'b1, 8'h10, 14'h1234, 8'h00);
    step(1'b0, 8'h10, 14'h0000, 8'h00);
    step(1'b0, 8'h00, 14'h0000, 8'h10);
    flush();

    tag = "rd_during_wr";
    step(1'b1, 8'h20, 14'h0AAA, 8'h00);
    step(1'b1, 8'h20, 14'h1555, 8'h20);
    step(1'b0, 8'h00, 14'h0000, 8'h20);
    flush();

    tag = "stream_pre_rst";
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 14'h0000, 8'(i));
    do_reset();
    tag = "retained_05";
    step(1'b0, 8'h00, 14'h0000, 8'h05);
    flush();

    tag = "boundary";
    step(1'b1, 8'hFF, 14'h3FFF, 8'h00);
    step(1'b1, 8'h00, 14'h0001, 8'h00);
    step(1'b0, 8'h00, 14'h0000, 8'hFF);
    step(1'b0, 8'h00, 14'h0000, 8'h00);
    flush();

    tag = "independent";
    step(1'b1, 8'h41, 14'h00F0, 8'h00);
    step(1'b1, 8'h40, 14'h0F0F, 8'h41);
    step(1'b0, 8'h00, 14'h0000, 8'h40);
    flush();

    // Random mix; about a third of cycles read the address being written.
    tag = "random";
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      d = 14'($urandom);
      step(1'($urandom), a, d, ($urandom_range(0, 2) == 0) ? a : 8'($urandom));
    end
    flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
